// File: rtl/spi_sched_pkg.sv
// Shared types and constants for the SPI bus scheduler: state encoding,
// bus-owner (grant) codes and default timing parameters.
package spi_sched_pkg;

    typedef enum logic [2:0] {
        ST_INIT_AMP = 3'd0,
        ST_IDLE     = 3'd1,
        ST_AMP      = 3'd2,
        ST_ADC      = 3'd3,
        ST_DAC      = 3'd4
    } sched_state_t;

    localparam logic [1:0] GRANT_NONE = 2'd0;
    localparam logic [1:0] GRANT_AMP  = 2'd1;
    localparam logic [1:0] GRANT_ADC  = 2'd2;
    localparam logic [1:0] GRANT_DAC  = 2'd3;

    localparam int DEFAULT_SAMPLE_PERIOD = 2000;
    localparam int DEFAULT_TIMEOUT       = 4095;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running wrap counter 0..PERIOD-1; tick is high for the single cycle
// in which the counter holds PERIOD-1.
module sample_tick_gen #(
    parameter int PERIOD = 2000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_bus_scheduler.sv
// Owner-select scheduler for the shared SPI bus: pre-amp gain, ADC read, DAC write.
// Optional bus-hold watchdog is built when SPI_SCHED_TIMEOUT_EN is defined.
module spi_bus_scheduler
    import spi_sched_pkg::*;
#(
    parameter int SAMPLE_PERIOD = DEFAULT_SAMPLE_PERIOD,
    parameter int TIMEOUT       = DEFAULT_TIMEOUT
) (
    input  logic       CLK_50M,
    input  logic       reset,
    input  logic       gain_req,
    input  logic       amp_done,
    input  logic       adc_done,
    input  logic       dac_done,
    output logic       amp_start,
    output logic       adc_start,
    output logic       dac_start,
    output logic [1:0] grant,
    output logic       busy,
    output logic [7:0] overrun_cnt,
    output logic       timeout_err
);

    sched_state_t state, next_state;
    logic         entry;       // first cycle spent in the current state
    logic         gain_pend, samp_pend;
    logic         gain_take, samp_take;
    logic         tick;
    logic         wd_fire;

    sample_tick_gen #(.PERIOD(SAMPLE_PERIOD)) u_tick (
        .clk   (CLK_50M),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state <= ST_INIT_AMP;
            entry <= 1'b0;
        end else begin
            state <= next_state;
            entry <= (next_state != state);
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        gain_take  = 1'b0;
        samp_take  = 1'b0;
        case (state)
            ST_INIT_AMP: next_state = ST_AMP;
            ST_IDLE: begin
                if (gain_pend) begin
                    next_state = ST_AMP;
                    gain_take  = 1'b1;
                end else if (samp_pend) begin
                    next_state = ST_ADC;
                    samp_take  = 1'b1;
                end
            end
            ST_AMP:  if (amp_done) next_state = ST_IDLE;
            ST_ADC:  if (adc_done) next_state = ST_DAC;
            ST_DAC:  if (dac_done) next_state = ST_IDLE;
            default: next_state = ST_INIT_AMP;
        endcase
        if (wd_fire) next_state = ST_IDLE;
    end

    always_comb begin
        grant     = GRANT_NONE;
        amp_start = 1'b0;
        adc_start = 1'b0;
        dac_start = 1'b0;
        case (state)
            ST_AMP: begin
                grant     = GRANT_AMP;
                amp_start = entry;
            end
            ST_ADC: begin
                grant     = GRANT_ADC;
                adc_start = entry;
            end
            ST_DAC: begin
                grant     = GRANT_DAC;
                dac_start = entry;
            end
            default: grant = GRANT_NONE;
        endcase
        busy = (grant != GRANT_NONE);
    end

    // A tick that finds a sample already pending is dropped and counted.
    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            gain_pend   <= 1'b0;
            samp_pend   <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            gain_pend <= gain_req | (gain_pend & ~gain_take);
            if (samp_take || wd_fire) samp_pend <= 1'b0;
            if (tick && !samp_pend) samp_pend <= 1'b1;
            if (tick && samp_pend && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

`ifdef SPI_SCHED_TIMEOUT_EN
    localparam logic [11:0] WD_LAST = 12'(TIMEOUT - 1);

    logic [11:0] wd_cnt;
    logic        timeout_q;

    // Firing on TIMEOUT-1 lets the owner hold the bus for exactly TIMEOUT cycles.
    assign wd_fire = (grant != GRANT_NONE) && (wd_cnt == WD_LAST);

    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            wd_cnt    <= 12'd0;
            timeout_q <= 1'b0;
        end else begin
            if (next_state != state) begin
                wd_cnt <= 12'd0;
            end else if (grant != GRANT_NONE) begin
                wd_cnt <= wd_cnt + 12'd1;
            end
            if (wd_fire) timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    // TIMEOUT only matters when the watchdog is built.
    logic unused_timeout;
    assign unused_timeout = |12'(TIMEOUT);
    assign wd_fire        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// Directed bench for spi_bus_scheduler (SAMPLE_PERIOD=100, TIMEOUT=50);
// watchdog scenario runs when SPI_SCHED_TIMEOUT_EN is defined.
module tb_spi_bus_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       gain_req, amp_done, adc_done, dac_done;
    logic       amp_start, adc_start, dac_start, busy, timeout_err;
    logic [1:0] grant;
    logic [7:0] overrun_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    spi_bus_scheduler #(.SAMPLE_PERIOD(100), .TIMEOUT(50)) dut (
        .CLK_50M     (clk),
        .reset       (reset),
        .gain_req    (gain_req),
        .amp_done    (amp_done),
        .adc_done    (adc_done),
        .dac_done    (dac_done),
        .amp_start   (amp_start),
        .adc_start   (adc_start),
        .dac_start   (dac_start),
        .grant       (grant),
        .busy        (busy),
        .overrun_cnt (overrun_cnt),
        .timeout_err (timeout_err)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       amp_done;
        logic       adc_done;
        logic       dac_done;
        logic       exp_amp_start;
        logic [1:0] exp_grant;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Outputs are read 1 time unit after the edge; pulses last one cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
        gain_req = 1'b0;
        amp_done = 1'b0;
        adc_done = 1'b0;
        dac_done = 1'b0;
    endtask

    task automatic goto(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic check_owner(input string name, input logic [1:0] g, input logic a, input logic d, input logic w);
        check({name, "_grant"}, 32'(grant), 32'(g));
        check({name, "_busy"}, 32'(busy), 32'(g != 2'd0));
        check({name, "_starts"}, 32'({amp_start, adc_start, dac_start}), 32'({a, d, w}));
    endtask

    initial begin
        int base;
        // cycle 0 is the first cycle after reset release; done pulses outside their owner are ignored
        for (int i = 0; i < 13; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};

        reset    = 1'b1;
        gain_req = 1'b0;
        amp_done = 1'b0;
        adc_done = 1'b0;
        dac_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        cyc   = 0;

        for (int i = 0; i < 13; i++) begin
            check($sformatf("vec%0d_out", i),
                  32'({amp_start, adc_start, dac_start, grant, busy}),
                  32'({vecs[i].exp_amp_start, 1'b0, 1'b0, vecs[i].exp_grant, vecs[i].exp_busy}));
            amp_done = vecs[i].amp_done;
            adc_done = vecs[i].adc_done;
            dac_done = vecs[i].dac_done;
            next_cycle();
        end

        // idle tick at cycle 99 -> adc_start at cycle 101
        goto(100); check_owner("tick_wait", 2'd0, 1'b0, 1'b0, 1'b0);
        goto(101); check_owner("tick_adc", 2'd2, 1'b0, 1'b1, 1'b0);
        goto(102); check_owner("adc_hold", 2'd2, 1'b0, 1'b0, 1'b0);
        goto(140); check("adc_wait_grant", 32'(grant), 32'd2); adc_done = 1'b1;
        goto(141); check_owner("dac_entry", 2'd3, 1'b0, 1'b0, 1'b1);
        goto(142); check_owner("dac_hold", 2'd3, 1'b0, 1'b0, 1'b0);
        goto(145); dac_done = 1'b1;
        goto(146); check_owner("dac_to_idle", 2'd0, 1'b0, 1'b0, 1'b0);

        // gain_req and tick together at cycle 199: AMP first, then ADC
        goto(199); gain_req = 1'b1;
        goto(200); check_owner("both_idle", 2'd0, 1'b0, 1'b0, 1'b0);
        goto(201); check_owner("both_amp", 2'd1, 1'b1, 1'b0, 1'b0);
        goto(205); amp_done = 1'b1;
        goto(206); check_owner("both_gap", 2'd0, 1'b0, 1'b0, 1'b0);
        goto(207); check_owner("both_adc", 2'd2, 1'b0, 1'b1, 1'b0);
        goto(210); adc_done = 1'b1;
        goto(211); check_owner("both_dac", 2'd3, 1'b0, 1'b0, 1'b1);
        goto(212); dac_done = 1'b1;
        goto(213); check_owner("both_end", 2'd0, 1'b0, 1'b0, 1'b0);
        check("both_overrun", 32'(overrun_cnt), 32'd0);

        goto(301); check_owner("ovr_adc", 2'd2, 1'b0, 1'b1, 1'b0);
`ifdef SPI_SCHED_TIMEOUT_EN
        // DAC entered at 306 and never answered: IDLE 50 cycles later
        goto(305); adc_done = 1'b1;
        goto(306); check_owner("wd_dac", 2'd3, 1'b0, 1'b0, 1'b1);
        goto(355); check("wd_hold_grant", 32'(grant), 32'd3);
        check("wd_hold_err", 32'(timeout_err), 32'd0);
        goto(356); check_owner("wd_idle", 2'd0, 1'b0, 1'b0, 1'b0);
        check("wd_err", 32'(timeout_err), 32'd1);
        goto(360); check("wd_err_sticky", 32'(timeout_err), 32'd1);
        check("wd_stay_idle", 32'(grant), 32'd0);
        base = 400;
`else
        // ADC held 300 cycles: ticks at 399 (pends), 499 and 599 (dropped)
        goto(550); check("ovr_one", 32'(overrun_cnt), 32'd1);
        goto(600); check("ovr_two", 32'(overrun_cnt), 32'd2); adc_done = 1'b1;
        goto(601); check_owner("ovr_dac", 2'd3, 1'b0, 1'b0, 1'b1);
        goto(605); dac_done = 1'b1;
        goto(606); check_owner("ovr_gap", 2'd0, 1'b0, 1'b0, 1'b0);
        goto(607); check_owner("ovr_pending", 2'd2, 1'b0, 1'b1, 1'b0);
        goto(610); adc_done = 1'b1;
        goto(611); check_owner("ovr_dac2", 2'd3, 1'b0, 1'b0, 1'b1);
        goto(612); dac_done = 1'b1;
        goto(620); check_owner("ovr_single", 2'd0, 1'b0, 1'b0, 1'b0);
        check("ovr_final", 32'(overrun_cnt), 32'd2);
        check("no_timeout_err", 32'(timeout_err), 32'd0);
        base = 700;
`endif

        // reset asserted during DAC
        goto(base + 1); check_owner("rst_adc", 2'd2, 1'b0, 1'b1, 1'b0);
        goto(base + 5); adc_done = 1'b1;
        goto(base + 6); check_owner("rst_dac", 2'd3, 1'b0, 1'b0, 1'b1);
        goto(base + 8); reset = 1'b1;
        goto(base + 9); check_owner("rst_mid", 2'd0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_overrun", 32'(overrun_cnt), 32'd0);
        check("rst_mid_err", 32'(timeout_err), 32'd0);
        goto(base + 10); reset = 1'b0;
        check_owner("rst_init", 2'd0, 1'b0, 1'b0, 1'b0);
        goto(base + 11); check_owner("rst_amp", 2'd1, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_bus_scheduler.md
# spi_bus_scheduler

Sequences the shared SPI bus (SPI_SCK/SPI_MOSI) between the pre-amplifier gain programmer, the ADC conversion reader and the DAC writer. It replaces ad-hoc MOSI muxing with one owner-select (`grant`) and start/done handshakes. Starts happen in a fixed order: gain programming, then ADC conversion, then DAC write of that sample. A free-running sample timer triggers conversions, and late or missing completions are counted.

## Interface
- `SAMPLE_PERIOD`, default 2000: CLK_50M cycles between sample ticks; legal range is 16 to 2^20−1.
- `TIMEOUT`, default 4095: maximum cycles a granted requester may hold the bus before it is aborted (only with the timeout feature).
- `CLK_50M` input, 1 bit: the single clock. All logic is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `gain_req` input, 1 bit: single-cycle pulse; the gain code changed and the pre-amp must be reprogrammed.
- `amp_done` input, 1 bit: single-cycle pulse from the pre-amp programmer; transfer finished.
- `adc_done` input, 1 bit: single-cycle pulse from the ADC reader; Va/Vb are valid.
- `dac_done` input, 1 bit: single-cycle pulse from the DAC writer; both channels are written.
- `amp_start` output, 1 bit: single-cycle start pulse to the pre-amp programmer.
- `adc_start` output, 1 bit: single-cycle start pulse to the ADC reader; drives AD_CONV sequencing.
- `dac_start` output, 1 bit: single-cycle start pulse to the DAC writer.
- `grant` output, 2 bits: bus owner. 0 = none, 1 = AMP, 2 = ADC, 3 = DAC. The top-level MOSI/CS mux uses it.
- `busy` output, 1 bit: high whenever `grant` is not 0.
- `overrun_cnt` output, 8 bits: number of dropped sample ticks; saturates at 255.
- `timeout_err` output, 1 bit: sticky flag; a requester was aborted (only with the timeout feature).

## Operation
- **States:** INIT_AMP, IDLE, AMP, ADC, DAC.
- **Reset values:**
  - State is INIT_AMP.
  - `grant` = 0; all start outputs are 0; `busy` = 0.
  - `overrun_cnt` = 0; `timeout_err` = 0.
  - The sample counter and both pending flags are 0.
- **INIT_AMP:** on the first cycle after reset deasserts, go to AMP unconditionally. The pre-amp is always programmed before any conversion.
- **AMP:**
  - `grant` = 1.
  - `amp_start` pulses on the first cycle in the state.
  - On `amp_done`, go to IDLE.
- **ADC:**
  - `grant` = 2.
  - `adc_start` pulses on the first cycle in the state.
  - On `adc_done`, go to DAC.
- **DAC:**
  - `grant` = 3.
  - `dac_start` pulses on the first cycle in the state.
  - On `dac_done`, go to IDLE.
- **IDLE:**
  - `grant` = 0.
  - If `gain_pend` is set, go to AMP and clear `gain_pend`.
  - Otherwise, if `samp_pend` is set, go to ADC and clear `samp_pend`.
  - Gain has priority over a sample.
- **Pending flags:**
  - `gain_req` in any state sets `gain_pend`; multiple requests merge into one.
  - A sample tick sets `samp_pend`.
  - A tick that arrives while `samp_pend` is already set increments `overrun_cnt`, and that tick is dropped.
- **Sample counter:**
  - Counts 0 to SAMPLE_PERIOD−1 and wraps.
  - The tick fires on the cycle the counter equals SAMPLE_PERIOD−1.
  - It runs in every state except during reset.
- **Done pulses outside the owner's state** (for example, `adc_done` during AMP) are ignored.
- **ADC-to-DAC chaining** is never interrupted by `gain_req`. Gain is serviced after the DAC write, so each DAC write uses the data captured under one gain setting.

## Timing
- **Entering a state from IDLE:** the state and `grant` change on edge N; the start pulse is high during cycle N, i.e. the first cycle of the new state.
- **Done handling:** a done pulse sampled at edge M moves the state at edge M. IDLE is therefore held for at least 1 cycle between owners, so `grant` passes through 0 for at least 1 cycle.
- **Tick-to-start latency when idle:** 2 cycles from the tick cycle to the `adc_start` cycle.
- **`gain_req` and tick in the same cycle while idle:** AMP is served first, then ADC; `samp_pend` is retained.
- **`reset` asserted mid-transfer:** all outputs return to their reset values on the next edge. The next transfer is a fresh INIT_AMP. The state of the driven sub-drivers is not tracked; they must be reset from the same signal.

## Configuration
- Macro: `SPI_SCHED_TIMEOUT_EN`.
- **Defined:**
  - A 12-bit watchdog counter resets on every state entry and counts while `grant` is not 0.
  - When it reaches TIMEOUT, the scheduler forces IDLE, sets `timeout_err`, and discards `samp_pend`.
  - `timeout_err` clears only on reset.
- **Undefined:**
  - No watchdog logic is built.
  - `timeout_err` is tied to 0.
  - The scheduler waits indefinitely for the done pulse.

## Structure
- Package `spi_sched_pkg` holds:
  - the state encoding;
  - the grant codes `GRANT_NONE`, `GRANT_AMP`, `GRANT_ADC` and `GRANT_DAC`;
  - the default SAMPLE_PERIOD and TIMEOUT constants.
- One sub-module, `sample_tick_gen`: a parameterised wrap counter emitting a single-cycle tick. It is reused by other lab designs.

## Test plan
- **Reset release:** deassert `reset`, then answer `amp_done` 10 cycles later. Expect `amp_start` exactly once, `grant` = 1 until the done pulse, then `grant` = 0.
- **Idle tick with SAMPLE_PERIOD = 100:** expect `adc_start` 2 cycles after each tick. Return `adc_done` after 40 cycles. Expect `dac_start` next, and `grant` sequencing 2 → 3 → 0.
- **Simultaneous `gain_req` and tick while idle:** expect AMP to be served first and then ADC; `overrun_cnt` stays 0.
- **Hold `adc_done` off for 3 × SAMPLE_PERIOD (timeout disabled):** `overrun_cnt` = 2, and exactly one pending sample is served after DAC completes.
- **With `SPI_SCHED_TIMEOUT_EN`, TIMEOUT = 50, and `dac_done` never sent:** at 50 cycles after DAC entry, state is IDLE, `timeout_err` = 1, and `grant` = 0.
- **Assert `reset` during DAC:** all outputs return to their reset values on the next edge, and INIT_AMP restarts the sequence.
